// File: rtl/spi_arb_pkg.sv
// Shared encodings for the SPI flash arbiter: FSM states, bus owner codes and
// small elaboration-time helpers.
package spi_arb_pkg;

   typedef enum logic [2:0] {
      CPU       = 3'd0,
      HALT_REQ  = 3'd1,
      GUARD_IN  = 3'd2,
      HOST      = 3'd3,
      GUARD_OUT = 3'd4,
      EXIT_RST  = 3'd5
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_CPU  = 2'd0,
      OWN_HOST = 2'd1,
      OWN_NONE = 2'd2
   } owner_e;

   function automatic owner_e state_owner(arb_state_e st);
      case (st)
         CPU, HALT_REQ: return OWN_CPU;
         HOST:          return OWN_HOST;
         default:       return OWN_NONE;
      endcase
   endfunction

   function automatic int max_of3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Flash, host, CPU-side and 6809 handshake signals of the arbiter, grouped as one
// bundle; the arbiter uses the slave view, its environment the master view.
interface spi_flash_arbiter_if #(
   parameter int NUM_CS = 2
);
   logic [NUM_CS-1:0] i_FT_CS_N;
   logic              i_FT_SCK;
   logic              i_FT_MOSI;
   logic              o_FT_MISO;
   logic              o_FT_MISO_OE;
   logic [NUM_CS-1:0] i_CPU_CS_N;
   logic              i_CPU_SCK;
   logic              i_CPU_MOSI;
   logic              o_CPU_MISO;
   logic [NUM_CS-1:0] o_SPI_CS_N;
   logic              o_SPI_CLK;
   logic              o_SPI_MOSI;
   logic              i_SPI_MISO;
   logic              i_BA;
   logic              i_BS;
   logic              o_HALT;
   logic              o_RESET;
   logic              o_HOST_OWNS;
   logic              o_HALT_TIMEOUT;

   modport slave (
      input  i_FT_CS_N, i_FT_SCK, i_FT_MOSI,
      input  i_CPU_CS_N, i_CPU_SCK, i_CPU_MOSI,
      input  i_SPI_MISO, i_BA, i_BS,
      output o_FT_MISO, o_FT_MISO_OE, o_CPU_MISO,
      output o_SPI_CS_N, o_SPI_CLK, o_SPI_MOSI,
      output o_HALT, o_RESET, o_HOST_OWNS, o_HALT_TIMEOUT
   );

   modport master (
      output i_FT_CS_N, i_FT_SCK, i_FT_MOSI,
      output i_CPU_CS_N, i_CPU_SCK, i_CPU_MOSI,
      output i_SPI_MISO, i_BA, i_BS,
      input  o_FT_MISO, o_FT_MISO_OE, o_CPU_MISO,
      input  o_SPI_CS_N, o_SPI_CLK, o_SPI_MOSI,
      input  o_HALT, o_RESET, o_HOST_OWNS, o_HALT_TIMEOUT
   );
endinterface

// File: rtl/spi_flash_arbiter_sync_bit.sv
// Single-bit flop-chain synchronizer with a selectable reset value so that
// active-low inputs can come out of reset in their inactive state.
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_CLK,
   input  logic i_RST,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d    = chain_q << 1;
      chain_d[0] = i_d;
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) chain_q <= {STAGES{RST_VAL}};
      else       chain_q <= chain_d;
   end

   assign o_q = chain_q[STAGES-1];
endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates the flash chip selects between the FT2232 host and the 6809-side
// SPI master, halting the 6809 before any host grant.
//
// state     | meaning
// CPU       | CPU master owns the flash, no halt
// HALT_REQ  | host asked; halt raised, waiting for BA&BS or timeout
// GUARD_IN  | nobody drives the flash, guard before host grant
// HOST      | host owns the flash
// GUARD_OUT | nobody drives the flash, guard after host release
// EXIT_RST  | 6809 held in reset before the CPU gets the bus back
module spi_flash_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_CS        = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int HALT_TIMEOUT  = 4096,
   parameter int GUARD_CYCLES  = 16,
   parameter int RESET_ON_EXIT = 1,
   parameter int RESET_CYCLES  = 64
) (
   input  logic               i_CLK,
   input  logic               i_RST,
   spi_flash_arbiter_if.slave bus
);
   localparam int MAX_CNT = max_of3(HALT_TIMEOUT, GUARD_CYCLES, RESET_CYCLES);
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   // Counters load N-1 and exit on zero, so each timed state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LD_HALT  = CNT_W'(HALT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LD_GUARD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RESET_CYCLES - 1);

   logic [NUM_CS-1:0] ft_cs_n_s;
   logic              halt_ack;
   logic              cpu_idle;
   logic              host_req;

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              rst_hold_q, rst_hold_d;

   for (genvar i = 0; i < NUM_CS; i++) begin : g_ft_sync
      sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
         .i_CLK (i_CLK),
         .i_RST (i_RST),
         .i_d   (bus.i_FT_CS_N[i]),
         .o_q   (ft_cs_n_s[i])
      );
   end

   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ack (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .i_d   (bus.i_BA & bus.i_BS),
      .o_q   (halt_ack)
   );

   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_idle (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .i_d   (&bus.i_CPU_CS_N),
      .o_q   (cpu_idle)
   );

   assign host_req = ~&ft_cs_n_s;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      rst_hold_d = rst_hold_q;
      unique case (state_q)
         CPU: begin
            if (host_req) begin
               state_d = HALT_REQ;
               cnt_d   = LD_HALT;
            end
         end
         HALT_REQ: begin
            if (!host_req) begin
               state_d = CPU;
            end else if (halt_ack && cpu_idle) begin
               state_d = GUARD_IN;
               cnt_d   = LD_GUARD;
            end else if (cnt_q == '0) begin
               // Forced grant: keep the 6809 in reset until the bus comes back.
               state_d    = GUARD_IN;
               cnt_d      = LD_GUARD;
               timeout_d  = 1'b1;
               rst_hold_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GUARD_IN: begin
            if (cnt_q == '0) state_d = HOST;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         HOST: begin
            if (!host_req) begin
               state_d = GUARD_OUT;
               cnt_d   = LD_GUARD;
            end
         end
         GUARD_OUT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (RESET_ON_EXIT != 0) begin
               state_d = EXIT_RST;
               cnt_d   = LD_RST;
            end else begin
               state_d    = CPU;
               rst_hold_d = 1'b0;
            end
         end
         EXIT_RST: begin
            if (cnt_q == '0) begin
               state_d    = CPU;
               rst_hold_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = CPU;
         end
      endcase
      owner_d = state_owner(state_d);
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q    <= CPU;
         owner_q    <= OWN_CPU;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         rst_hold_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         rst_hold_q <= rst_hold_d;
      end
   end

   // SCK and data pass straight through; only the owner select is registered.
   always_comb begin
      bus.o_SPI_CS_N   = '1;
      bus.o_SPI_CLK    = 1'b0;
      bus.o_SPI_MOSI   = 1'b0;
      bus.o_CPU_MISO   = 1'b0;
      bus.o_FT_MISO    = 1'b0;
      bus.o_FT_MISO_OE = 1'b0;
      case (owner_q)
         OWN_CPU: begin
            bus.o_SPI_CS_N = bus.i_CPU_CS_N;
            bus.o_SPI_CLK  = bus.i_CPU_SCK;
            bus.o_SPI_MOSI = bus.i_CPU_MOSI;
            bus.o_CPU_MISO = bus.i_SPI_MISO;
         end
         OWN_HOST: begin
            bus.o_SPI_CS_N   = bus.i_FT_CS_N;
            bus.o_SPI_CLK    = bus.i_FT_SCK;
            bus.o_SPI_MOSI   = bus.i_FT_MOSI;
            bus.o_FT_MISO    = bus.i_SPI_MISO;
            bus.o_FT_MISO_OE = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.o_HALT         = (state_q != CPU);
   assign bus.o_RESET        = rst_hold_q | (state_q == EXIT_RST);
   assign bus.o_HOST_OWNS    = (owner_q == OWN_HOST);
   assign bus.o_HALT_TIMEOUT = timeout_q;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter: expected status changes and data-path
// values are queued from an edge-count timeline model and checked by a monitor.
module tb_spi_flash_arbiter;
   localparam int NCS     = 2;
   localparam int SYNC    = 2;
   localparam int TMO     = 4096;
   localparam int GUARD   = 16;
   localparam int RST_LEN = 64;
   localparam int O_CPU   = 0;
   localparam int O_HOST  = 1;
   localparam int O_NONE  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_flash_arbiter_if #(.NUM_CS(NCS)) bus();

   spi_flash_arbiter #(
      .NUM_CS(NCS), .SYNC_STAGES(SYNC), .HALT_TIMEOUT(TMO),
      .GUARD_CYCLES(GUARD), .RESET_ON_EXIT(1), .RESET_CYCLES(RST_LEN)
   ) dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus)
   );

   typedef struct { int e; logic [6:0] v; } st_ev_t;
   typedef struct { int e; logic [3:0] v; } dat_ev_t;

   st_ev_t     sq[$];
   dat_ev_t    dq[$];
   int         edge_n     = 0;
   int         compared   = 0;
   int         mismatched = 0;
   logic       mon_en     = 1'b0;
   logic [6:0] prev       = '0;
   logic [6:0] status;

   // {halt, reset, host_owns, timeout, miso_oe, spi_cs_n}
   assign status = {bus.o_HALT, bus.o_RESET, bus.o_HOST_OWNS, bus.o_HALT_TIMEOUT,
                    bus.o_FT_MISO_OE, bus.o_SPI_CS_N};

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [6:0] st_vec(logic h, logic r, logic o, logic t, logic [1:0] cs);
      return {h, r, o, t, o, cs};
   endfunction

   function automatic logic [1:0] pick_cs();
      case ($urandom_range(0, 2))
         0:       return 2'b00;
         1:       return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(int n);
      if (edge_n > n) begin
         compared++;
         mismatched++;
         $display("FAIL schedule: now at edge %0d, required edge %0d", edge_n, n);
      end
      while (edge_n < n) tick();
   endtask

   task automatic push_st(int e, logic [6:0] v);
      st_ev_t x;
      x.e = e;
      x.v = v;
      sq.push_back(x);
   endtask

   // Random SCK/MOSI/MISO per cycle; expected pass-through follows the owner.
   task automatic data_run(int own, int n);
      for (int i = 0; i < n; i++) begin
         dat_ev_t x;
         tick();
         bus.i_CPU_SCK  = 1'($urandom_range(0, 1));
         bus.i_CPU_MOSI = 1'($urandom_range(0, 1));
         bus.i_FT_SCK   = 1'($urandom_range(0, 1));
         bus.i_FT_MOSI  = 1'($urandom_range(0, 1));
         bus.i_SPI_MISO = 1'($urandom_range(0, 1));
         x.e = edge_n;
         if (own == O_CPU)
            x.v = {bus.i_CPU_SCK, bus.i_CPU_MOSI, bus.i_SPI_MISO, 1'b0};
         else if (own == O_HOST)
            x.v = {bus.i_FT_SCK, bus.i_FT_MOSI, 1'b0, bus.i_SPI_MISO};
         else
            x.v = 4'b0000;
         dq.push_back(x);
      end
   endtask

   always @(negedge clk) begin : monitor
      st_ev_t  se;
      dat_ev_t de;
      if (mon_en && (status !== prev)) begin
         compared++;
         if (sq.size() == 0) begin
            mismatched++;
            $display("FAIL status_unexpected: edge %0d got %b, no change expected", edge_n, status);
         end else begin
            se = sq.pop_front();
            if (se.v !== status || se.e != edge_n) begin
               mismatched++;
               $display("FAIL status: got %b at edge %0d, required %b at edge %0d",
                        status, edge_n, se.v, se.e);
            end
         end
         prev = status;
      end
      while (dq.size() > 0 && dq[0].e <= edge_n) begin
         de = dq.pop_front();
         compared++;
         if (de.e != edge_n) begin
            mismatched++;
            $display("FAIL datapath_stale: entry for edge %0d seen at edge %0d", de.e, edge_n);
         end else if ({bus.o_SPI_CLK, bus.o_SPI_MOSI, bus.o_CPU_MISO, bus.o_FT_MISO} !== de.v) begin
            mismatched++;
            $display("FAIL datapath: edge %0d got clk/mosi/cpu_miso/ft_miso=%b required %b",
                     edge_n, {bus.o_SPI_CLK, bus.o_SPI_MOSI, bus.o_CPU_MISO, bus.o_FT_MISO}, de.v);
         end
      end
   end

   initial begin
      #(10 * 30000);
      $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s, a, g, r, x, d;
      logic [1:0] p;
      bus.i_FT_CS_N  = '1;
      bus.i_FT_SCK   = 1'b0;
      bus.i_FT_MOSI  = 1'b0;
      bus.i_CPU_CS_N = 2'b10;
      bus.i_CPU_SCK  = 1'b0;
      bus.i_CPU_MOSI = 1'b0;
      bus.i_SPI_MISO = 1'b0;
      bus.i_BA       = 1'b0;
      bus.i_BS       = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (status !== st_vec(0, 0, 0, 0, 2'b10)) begin
         mismatched++;
         $display("FAIL reset_state: got %b required %b", status, st_vec(0, 0, 0, 0, 2'b10));
      end
      prev   = st_vec(0, 0, 0, 0, 2'b10);
      mon_en = 1'b1;
      data_run(O_CPU, 8);

      // Acknowledged host session with exit reset.
      tick();
      bus.i_CPU_CS_N = '1;
      push_st(edge_n, st_vec(0, 0, 0, 0, 2'b11));
      repeat (4) tick();
      p = pick_cs();
      tick();
      s = edge_n;
      bus.i_FT_CS_N = p;
      push_st(s + SYNC + 1, st_vec(1, 0, 0, 0, 2'b11));
      d = $urandom_range(1, 20);
      a = s + d;
      wait_edge(a);
      bus.i_BA = 1'b1;
      bus.i_BS = 1'b1;
      g = ((s + SYNC + 1 > a + SYNC) ? s + SYNC + 1 : a + SYNC) + 1;
      push_st(g + GUARD, st_vec(1, 0, 1, 0, p));
      wait_edge(g + GUARD);
      data_run(O_HOST, $urandom_range(5, 20));
      tick();
      r = edge_n;
      bus.i_FT_CS_N = '1;
      bus.i_BA = 1'b0;
      bus.i_BS = 1'b0;
      push_st(r, st_vec(1, 0, 1, 0, 2'b11));
      push_st(r + SYNC + 1, st_vec(1, 0, 0, 0, 2'b11));
      push_st(r + SYNC + 1 + GUARD, st_vec(1, 1, 0, 0, 2'b11));
      push_st(r + SYNC + 1 + GUARD + RST_LEN, st_vec(0, 0, 0, 0, 2'b01));
      wait_edge(r + 5);
      bus.i_CPU_CS_N = 2'b01;
      data_run(O_NONE, 5);
      wait_edge(r + SYNC + 1 + GUARD + RST_LEN);
      data_run(O_CPU, 6);

      // Halt timeout: forced grant, reset held until the bus returns.
      tick();
      bus.i_CPU_CS_N = '1;
      push_st(edge_n, st_vec(0, 0, 0, 0, 2'b11));
      repeat (4) tick();
      p = pick_cs();
      tick();
      s = edge_n;
      bus.i_FT_CS_N = p;
      push_st(s + SYNC + 1, st_vec(1, 0, 0, 0, 2'b11));
      push_st(s + SYNC + 1 + TMO, st_vec(1, 1, 0, 1, 2'b11));
      push_st(s + SYNC + 1 + TMO + GUARD, st_vec(1, 1, 1, 1, p));
      wait_edge(s + SYNC + 1 + TMO + GUARD);
      data_run(O_HOST, 4);
      tick();
      r = edge_n;
      bus.i_FT_CS_N = '1;
      push_st(r, st_vec(1, 1, 1, 1, 2'b11));
      push_st(r + SYNC + 1, st_vec(1, 1, 0, 1, 2'b11));
      push_st(r + SYNC + 1 + GUARD + RST_LEN, st_vec(0, 0, 0, 1, 2'b11));
      wait_edge(r + SYNC + 1 + GUARD + RST_LEN + 2);

      // Short host pulse before any acknowledge: back to CPU, flash CS untouched.
      p = pick_cs();
      tick();
      s = edge_n;
      bus.i_FT_CS_N = p;
      push_st(s + SYNC + 1, st_vec(1, 0, 0, 1, 2'b11));
      wait_edge(s + 5);
      bus.i_FT_CS_N = '1;
      push_st(s + 5 + SYNC + 1, st_vec(0, 0, 0, 1, 2'b11));
      wait_edge(s + 12);

      // Reset while the host owns the bus.
      p = pick_cs();
      tick();
      s = edge_n;
      bus.i_FT_CS_N = p;
      push_st(s + SYNC + 1, st_vec(1, 0, 0, 1, 2'b11));
      d = $urandom_range(1, 10);
      a = s + d;
      wait_edge(a);
      bus.i_BA = 1'b1;
      bus.i_BS = 1'b1;
      g = ((s + SYNC + 1 > a + SYNC) ? s + SYNC + 1 : a + SYNC) + 1;
      push_st(g + GUARD, st_vec(1, 0, 1, 1, p));
      wait_edge(g + GUARD + $urandom_range(1, 5));
      x = edge_n;
      rst = 1'b1;
      push_st(x + 1, st_vec(0, 0, 0, 0, 2'b11));
      wait_edge(x + 1);
      rst = 1'b0;
      bus.i_FT_CS_N = '1;
      bus.i_BA = 1'b0;
      bus.i_BS = 1'b0;
      data_run(O_CPU, 4);
      repeat (4) tick();

      @(negedge clk);
      #1;
      while (sq.size() > 0) begin
         st_ev_t se;
         se = sq.pop_front();
         compared++;
         mismatched++;
         $display("FAIL status_missing: %b required at edge %0d never seen", se.v, se.e);
      end
      while (dq.size() > 0) begin
         dat_ev_t de;
         de = dq.pop_front();
         compared++;
         mismatched++;
         $display("FAIL datapath_missing: entry for edge %0d never checked", de.e);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Clocked successor to the FT2232/6809 SPI flash pass-through.
- Arbitrates NUM_CS flash chip selects between the FT2232 host port and the 6809-side SPI master.
- Before granting the bus to the host, it requests a 6809 halt and waits for the bus-available acknowledge.
- Adds a guard time on release, an optional reset pulse on exit, a halt timeout, and explicit output enables in place of internal tri-states.

Parameters:
- NUM_CS, 2, number of flash chip selects (1..8)
- SYNC_STAGES, 2, synchronizer depth for FT CS and BA/BS
- HALT_TIMEOUT, 4096, i_CLK cycles to wait for halt ack before forcing
- GUARD_CYCLES, 16, cycles with all flash CS deasserted on every ownership change
- RESET_ON_EXIT, 1, 1 = pulse o_RESET after host session ends
- RESET_CYCLES, 64, length of the exit reset pulse

Ports:
- i_CLK  in  1  system clock
- i_RST  in  1  synchronous active-high reset
- i_FT_CS_N  in  NUM_CS  host chip selects, active low, asynchronous
- i_FT_SCK  in  1  host SPI clock
- i_FT_MOSI  in  1  host MOSI
- o_FT_MISO  out  1  MISO to host
- o_FT_MISO_OE  out  1  host MISO drive enable
- i_CPU_CS_N  in  NUM_CS  CPU-side chip selects, active low
- i_CPU_SCK  in  1  CPU-side SPI clock
- i_CPU_MOSI  in  1  CPU-side MOSI
- o_CPU_MISO  out  1  MISO to CPU-side master
- o_SPI_CS_N  out  NUM_CS  flash chip selects
- o_SPI_CLK  out  1  flash clock
- o_SPI_MOSI  out  1  flash MOSI
- i_SPI_MISO  in  1  flash MISO
- i_BA  in  1  6809 bus available
- i_BS  in  1  6809 bus status
- o_HALT  out  1  halt request to 6809, active high
- o_RESET  out  1  reset to 6809, active high
- o_HOST_OWNS  out  1  1 while host owns the flash bus
- o_HALT_TIMEOUT  out  1  sticky; set on forced grant, cleared only by i_RST

Behaviour:
- Reset values (applied on the i_RST cycle, overriding any state):
  - State = CPU.
  - o_HALT = 0, o_RESET = 0, o_HOST_OWNS = 0, o_HALT_TIMEOUT = 0, o_FT_MISO_OE = 0.
  - Synchronizers and counter cleared.
  - A reset mid-session returns the bus to CPU immediately.
- Synchronized signals:
  - host_req = any bit of synchronized i_FT_CS_N low.
  - halt_ack = synchronized (i_BA & i_BS).
  - cpu_idle = all i_CPU_CS_N high, synchronized.
- Data path is combinational, muxed by the registered owner select. SCK is never resampled.
  - Owner CPU: o_SPI_* = i_CPU_*; o_CPU_MISO = i_SPI_MISO.
  - Owner HOST: o_SPI_* = i_FT_*; o_FT_MISO = i_SPI_MISO; o_FT_MISO_OE = 1.
  - Owner NONE: o_SPI_CS_N = all ones, o_SPI_CLK = 0, o_SPI_MOSI = 0.
  - The non-owning side's MISO is driven 0 (host side: OE = 0).
- State machine (one 3-bit state register; one shared down-counter of width clog2 of the max count parameter):
  - CPU: owner CPU.
    - host_req → HALT_REQ; load counter with HALT_TIMEOUT.
  - HALT_REQ: owner CPU, o_HALT = 1, counter decrements.
    - host_req drops → CPU; o_HALT = 0 next cycle; no guard, since the bus never changed owner.
    - halt_ack & cpu_idle → GUARD_IN; load GUARD_CYCLES.
    - Counter reaches 0 → GUARD_IN; set o_HALT_TIMEOUT; assert o_RESET until the EXIT_RST/CPU transition.
  - GUARD_IN: owner NONE, o_HALT = 1, counts GUARD_CYCLES, then → HOST.
  - HOST: owner HOST, o_HOST_OWNS = 1, o_HALT = 1.
    - Leaves only when host_req has been low for 1 synchronized cycle → GUARD_OUT; load GUARD_CYCLES.
  - GUARD_OUT: owner NONE, o_HALT = 1, counts GUARD_CYCLES.
    - A new host_req during GUARD_OUT is ignored until the state returns to CPU.
    - Count done → EXIT_RST if RESET_ON_EXIT, else → CPU.
  - EXIT_RST: owner NONE, o_HALT = 1, o_RESET = 1 for RESET_CYCLES, then → CPU.
    - o_HALT and o_RESET deassert on the same edge.
- Latency: first host CS-low edge to o_HALT = SYNC_STAGES + 1 cycles.
- Host CS edges arriving while the host does not own the bus never reach the flash.

Decomposition:
- Package spi_arb_pkg holds the state encoding constants (CPU, HALT_REQ, GUARD_IN, HOST, GUARD_OUT, EXIT_RST) and the owner encoding (OWN_CPU, OWN_HOST, OWN_NONE).
- One sub-module, sync_bit, a parametrised SYNC_STAGES flop chain, instanced per synchronized bit.

Test Plan:
- Reset, then drive i_CPU_CS_N = 2'b10 → o_SPI_CS_N = 2'b10; o_HALT = 0; o_FT_MISO_OE = 0.
- i_FT_CS_N = 2'b01; BA/BS = 1 after 10 cycles → o_HALT at cycle 3, o_SPI_CS_N = 2'b11 for 16 cycles, then 2'b01 and o_HOST_OWNS = 1.
- Host request with BA/BS held 0 → at cycle 4096 o_HALT_TIMEOUT = 1, o_RESET = 1, host granted after guard; flag stays 1 until i_RST.
- Host releases CS → 16 guard cycles, o_RESET high for 64 cycles, then o_HALT = 0 and the CPU path is restored on the same edge.
- Host CS pulses low for 5 cycles, before any ack → returns to CPU; the flash never sees host CS.
- i_RST asserted while in HOST → next cycle owner CPU, o_HALT = 0, o_HOST_OWNS = 0.
